frame_window_ctrl: RTL and testbench
====================================

Name: frame_window_ctrl

Overview:
- Register-window controller; sits directly upstream of the 16-entry windowed register file.
- Holds the frame pointer (FP) and a LIFO of CALL offsets.
- Translates window-relative operand indices (0-7) into absolute register addresses.
- Generates the FP_move / FP_push_up / New_FP controls for CALL and RTN, and stalls the front end for one settle cycle after each window move.

Parameters:
- NREGS, 16, physical register count; must be a power of two.
- WIN, 8, window size; maximum legal FP = NREGS-WIN = 8.
- DEPTH, 8, entries in the CALL-offset LIFO.

Ports:
- Clock  in  1  sole clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high.
- Instr_Valid  in  1  decoded instruction present.
- Instr_Ready  out  1  controller accepts the instruction this cycle.
- Is_Call  in  1  instruction is CALL.
- Is_Rtn  in  1  instruction is RTN.
- Call_Offset  in  3  I, the window advance for CALL.
- Rel_Rd, Rel_Rs, Rel_Rm  in  3 each  window-relative operand indices.
- Rd_Wen_In, Rs_Wen_In  in  1 each  requested writes.
- Rd_Addr, Rs_Addr, Rm_Addr  out  4 each  absolute addresses, (FP+rel) mod NREGS.
- Actual_Rd, Actual_Rm  out  3 each  Rel_Rd and Rel_Rm passed through.
- Actual_Rs  out  3  carries Rel_Rs normally; carries the move offset I during CALL or RTN.
- Rd_Wen, Rs_Wen  out  1 each  gated write enables.
- FP_move  out  1  window move this cycle.
- FP_push_up  out  1  1 = CALL (FP rises), 0 = RTN.
- New_FP  out  4  FP value after the move.
- Cur_FP  out  4  current FP.
- Depth  out  4  LIFO occupancy, 0..DEPTH.
- Fault  out  1  sticky fault flag.

Behaviour:
- Reset values: FP=0, Depth=0, LIFO cleared, state=RUN, Fault=0.
- Reset values of outputs: FP_move=0, Rd_Wen=Rs_Wen=0, Instr_Ready=1, New_FP=0.
- Reset asserted mid-move aborts the move; FP returns to 0.
- Address generation and enables are combinational from the current FP and inputs; there is no pipeline register.
- Accept condition: accept = Instr_Valid & Instr_Ready.

State machine:
- RUN: Instr_Ready=1.
  - Plain accepted instruction: Rd_Wen=Rd_Wen_In, Rs_Wen=Rs_Wen_In, FP_move=0.
  - Accepted CALL, legal: FP_move=1, FP_push_up=1, New_FP=FP+I, Actual_Rs=I, Rd_Wen=Rd_Wen_In, Rs_Wen=0. At the edge: FP<=FP+I, push I, Depth+1, go to SETTLE.
  - Accepted RTN, legal: FP_move=1, FP_push_up=0, I=LIFO top, New_FP=FP-I, Actual_Rs=I, Rd_Wen=Rd_Wen_In, Rs_Wen=0. At the edge: FP<=FP-I, pop, Depth-1, go to SETTLE.
- SETTLE: exactly one cycle.
  - Instr_Ready=0; all enables 0; FP_move=0.
  - Then return to RUN. This gives the register file one cycle to reload its window.
- FAULT: entered instead of the move.
  - Illegal CALL: FP+I > NREGS-WIN, or Depth==DEPTH.
  - Illegal RTN: Depth==0.
  - On entry: Fault=1, FP and LIFO unchanged, the faulting instruction's writes suppressed.
  - In FAULT: Instr_Ready=0 and all enables 0 until Reset.
- Arithmetic: FP+I is computed 5 bits wide before the legality compare. Address sums wrap modulo NREGS; with a legal FP they never wrap.
- Is_Call and Is_Rtn both set: treated as illegal, go to FAULT.
- CALL with I=0 is legal: FP_move pulses, FP unchanged, 0 is pushed.
- When New_FP==FP (CALL with I=0), Rd_Addr still uses the pre-move FP.
- Not accepted (Instr_Valid=0): no state change, all enables 0.

Decomposition:
- Shared package frame_pkg holds:
  - NREGS, WIN, FP_MAX constants;
  - fp_t (4-bit) and rel_t (3-bit) typedefs;
  - ctrl_state_t enum {RUN, SETTLE, FAULT}.
- One sub-module, offset_lifo: DEPTH x 3-bit stack with push, pop, top, full, empty and count.

Test Plan:
- Reset, then plain instruction with Rel_Rd=3, Rd_Wen_In=1 -> Rd_Addr=3, Rd_Wen=1, FP_move=0, Cur_FP=0.
- CALL I=4, Rel_Rd=2, Rd_Wen_In=1 from FP=0 -> FP_move=1, FP_push_up=1, New_FP=4, Actual_Rs=4, Rd_Addr=2. Next cycle Instr_Ready=0. Then Cur_FP=4, Depth=1; Rel_Rm=5 gives Rm_Addr=9.
- CALL 4, CALL 4, then RTN -> second CALL yields FP=8; RTN gives FP_push_up=0, Actual_Rs=4, New_FP=4, Depth back to 1.
- FP=8, CALL I=1 -> Fault=1, Cur_FP stays 8, Rd_Wen=0, Instr_Ready stays 0 until Reset.
- RTN at Depth=0 -> Fault=1, FP=0. Then assert Reset mid-cycle -> Fault=0, Instr_Ready=1 immediately (asynchronous).
- DEPTH+1 CALLs with I=0 -> the first DEPTH moves succeed with Depth=8; the ninth faults.

Source files
------------

// File: rtl/frame_pkg.sv
// Shared constants, typedefs and controller state encoding for the register-window controller.
package frame_pkg;

  localparam int unsigned NREGS  = 16;
  localparam int unsigned WIN    = 8;
  localparam int unsigned FP_MAX = NREGS - WIN;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned FP_W   = $clog2(NREGS);
  localparam int unsigned REL_W  = $clog2(WIN);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  typedef logic [FP_W-1:0]  fp_t;
  typedef logic [REL_W-1:0] rel_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SETTLE = 2'd1,
    FAULT  = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/frame_window_ctrl_offset_lifo.sv
// LIFO of CALL offsets; the top entry is the distance the next RTN moves the frame pointer back.
module offset_lifo
  import frame_pkg::*;
#(
  parameter int unsigned LDEPTH = DEPTH
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             push,
  input  logic             pop,
  input  rel_t             push_data,
  output rel_t             top,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(LDEPTH);

  rel_t             mem_q [LDEPTH];
  rel_t             mem_d [LDEPTH];
  logic [CNT_W-1:0] count_q, count_d;

  assign full  = (count_q == CNT_W'(LDEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign top   = empty ? '0 : mem_q[PTR_W'(count_q - CNT_W'(1))];

  // Push takes priority; the controller never requests both in one cycle.
  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    if (push && !full) begin
      mem_d[PTR_W'(count_q)] = push_data;
      count_d                = count_q + CNT_W'(1);
    end else if (pop && !empty) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count_q <= '0;
      for (int i = 0; i < int'(LDEPTH); i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: rtl/frame_window_ctrl.sv
// Register-window controller: frame pointer, CALL/RTN window moves, operand address translation
// and a one-cycle settle stall after each move.
module frame_window_ctrl
  import frame_pkg::*;
(
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Instr_Valid,
  output logic             Instr_Ready,
  input  logic             Is_Call,
  input  logic             Is_Rtn,
  input  rel_t             Call_Offset,
  input  rel_t             Rel_Rd,
  input  rel_t             Rel_Rs,
  input  rel_t             Rel_Rm,
  input  logic             Rd_Wen_In,
  input  logic             Rs_Wen_In,
  output fp_t              Rd_Addr,
  output fp_t              Rs_Addr,
  output fp_t              Rm_Addr,
  output rel_t             Actual_Rd,
  output rel_t             Actual_Rs,
  output rel_t             Actual_Rm,
  output logic             Rd_Wen,
  output logic             Rs_Wen,
  output logic             FP_move,
  output logic             FP_push_up,
  output fp_t              New_FP,
  output fp_t              Cur_FP,
  output logic [CNT_W-1:0] Depth,
  output logic             Fault
);

  ctrl_state_t state_q, state_d;
  fp_t         fp_q, fp_d;
  logic        fault_q, fault_d;

  logic             lifo_push, lifo_pop, lifo_full, lifo_empty;
  rel_t             lifo_top;
  logic [CNT_W-1:0] lifo_count;
  logic [FP_W:0]    call_sum;
  fp_t              call_fp, rtn_fp;
  logic             call_ok, rtn_ok;

  offset_lifo u_lifo (
    .Clock     (Clock),
    .Reset     (Reset),
    .push      (lifo_push),
    .pop       (lifo_pop),
    .push_data (Call_Offset),
    .top       (lifo_top),
    .full      (lifo_full),
    .empty     (lifo_empty),
    .count     (lifo_count)
  );

  // Sum is one bit wider so an overshoot past FP_MAX cannot alias back into range.
  assign call_sum = (FP_W+1)'(fp_q) + (FP_W+1)'(Call_Offset);
  assign call_fp  = fp_q + fp_t'(Call_Offset);
  assign rtn_fp   = fp_q - fp_t'(lifo_top);
  assign call_ok  = Is_Call && !Is_Rtn && (call_sum <= (FP_W+1)'(FP_MAX)) && !lifo_full;
  assign rtn_ok   = Is_Rtn && !Is_Call && !lifo_empty;

  assign Rd_Addr   = fp_q + fp_t'(Rel_Rd);
  assign Rs_Addr   = fp_q + fp_t'(Rel_Rs);
  assign Rm_Addr   = fp_q + fp_t'(Rel_Rm);
  assign Actual_Rd = Rel_Rd;
  assign Actual_Rm = Rel_Rm;
  assign Cur_FP    = fp_q;
  assign Depth     = lifo_count;
  assign Fault     = fault_q;

  always_comb begin
    state_d     = state_q;
    fp_d        = fp_q;
    fault_d     = fault_q;
    lifo_push   = 1'b0;
    lifo_pop    = 1'b0;
    Instr_Ready = 1'b0;
    Rd_Wen      = 1'b0;
    Rs_Wen      = 1'b0;
    FP_move     = 1'b0;
    FP_push_up  = 1'b0;
    New_FP      = fp_q;
    Actual_Rs   = Rel_Rs;
    unique case (state_q)
      RUN: begin
        Instr_Ready = 1'b1;
        if (Instr_Valid) begin
          if (call_ok) begin
            FP_move    = 1'b1;
            FP_push_up = 1'b1;
            New_FP     = call_fp;
            Actual_Rs  = Call_Offset;
            Rd_Wen     = Rd_Wen_In;
            fp_d       = call_fp;
            lifo_push  = 1'b1;
            state_d    = SETTLE;
          end else if (rtn_ok) begin
            FP_move   = 1'b1;
            New_FP    = rtn_fp;
            Actual_Rs = lifo_top;
            Rd_Wen    = Rd_Wen_In;
            fp_d      = rtn_fp;
            lifo_pop  = 1'b1;
            state_d   = SETTLE;
          end else if (Is_Call || Is_Rtn) begin
            fault_d = 1'b1;
            state_d = FAULT;
          end else begin
            Rd_Wen = Rd_Wen_In;
            Rs_Wen = Rs_Wen_In;
          end
        end
      end
      SETTLE:  state_d = RUN;
      FAULT:   state_d = FAULT;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= RUN;
      fp_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fp_q    <= fp_d;
      fault_q <= fault_d;
    end
  end

endmodule

// File: tb/tb_frame_window_ctrl.sv
// Scoreboard bench for frame_window_ctrl: a behavioural window model queues expected outputs each cycle.
module tb_frame_window_ctrl;
  import frame_pkg::*;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Instr_Valid = 1'b0, Is_Call = 1'b0, Is_Rtn = 1'b0;
  logic [2:0] Call_Offset = '0, Rel_Rd = '0, Rel_Rs = '0, Rel_Rm = '0;
  logic       Rd_Wen_In = 1'b0, Rs_Wen_In = 1'b0;
  logic       Instr_Ready, Rd_Wen, Rs_Wen, FP_move, FP_push_up, Fault;
  logic [3:0] Rd_Addr, Rs_Addr, Rm_Addr, New_FP, Cur_FP, Depth;
  logic [2:0] Actual_Rd, Actual_Rs, Actual_Rm;

  frame_window_ctrl dut (
    .Clock(Clock), .Reset(Reset), .Instr_Valid(Instr_Valid), .Instr_Ready(Instr_Ready),
    .Is_Call(Is_Call), .Is_Rtn(Is_Rtn), .Call_Offset(Call_Offset),
    .Rel_Rd(Rel_Rd), .Rel_Rs(Rel_Rs), .Rel_Rm(Rel_Rm),
    .Rd_Wen_In(Rd_Wen_In), .Rs_Wen_In(Rs_Wen_In),
    .Rd_Addr(Rd_Addr), .Rs_Addr(Rs_Addr), .Rm_Addr(Rm_Addr),
    .Actual_Rd(Actual_Rd), .Actual_Rs(Actual_Rs), .Actual_Rm(Actual_Rm),
    .Rd_Wen(Rd_Wen), .Rs_Wen(Rs_Wen), .FP_move(FP_move), .FP_push_up(FP_push_up),
    .New_FP(New_FP), .Cur_FP(Cur_FP), .Depth(Depth), .Fault(Fault)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: 0=RUN 1=SETTLE 2=FAULT
  int m_state = 0;
  int m_fp    = 0;
  int m_fault = 0;
  int m_stk[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      0:  return 32'(Instr_Ready);
      1:  return 32'(Rd_Addr);
      2:  return 32'(Rs_Addr);
      3:  return 32'(Rm_Addr);
      4:  return 32'(Actual_Rd);
      5:  return 32'(Actual_Rs);
      6:  return 32'(Actual_Rm);
      7:  return 32'(Rd_Wen);
      8:  return 32'(Rs_Wen);
      9:  return 32'(FP_move);
      10: return 32'(FP_push_up);
      11: return 32'(New_FP);
      12: return 32'(Cur_FP);
      13: return 32'(Depth);
      14: return 32'(Fault);
      default: return 32'hdead_beef;
    endcase
  endfunction

  function automatic void expect_out(input string tag, input int sel, input int val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = 32'(val);
    exp_q.push_back(e);
  endfunction

  function automatic void model_expect(input string tag);
    int  top, off_i;
    bit  ready, acc, call_ok, rtn_ok, mv, bad_mv;
    top     = (m_stk.size() > 0) ? m_stk[$] : 0;
    ready   = (m_state == 0);
    acc     = Instr_Valid && ready;
    call_ok = Is_Call && !Is_Rtn && (m_fp + int'(Call_Offset) <= 8) && (m_stk.size() < 8);
    rtn_ok  = Is_Rtn && !Is_Call && (m_stk.size() > 0);
    mv      = acc && (call_ok || rtn_ok);
    bad_mv  = acc && (Is_Call || Is_Rtn) && !mv;
    off_i   = call_ok ? int'(Call_Offset) : top;
    expect_out({tag, ".ready"}, 0, int'(ready));
    expect_out({tag, ".rd_addr"}, 1, (m_fp + int'(Rel_Rd)) % 16);
    expect_out({tag, ".rs_addr"}, 2, (m_fp + int'(Rel_Rs)) % 16);
    expect_out({tag, ".rm_addr"}, 3, (m_fp + int'(Rel_Rm)) % 16);
    expect_out({tag, ".act_rd"}, 4, int'(Rel_Rd));
    expect_out({tag, ".act_rs"}, 5, mv ? off_i : int'(Rel_Rs));
    expect_out({tag, ".act_rm"}, 6, int'(Rel_Rm));
    expect_out({tag, ".rd_wen"}, 7, int'(acc && Rd_Wen_In && !bad_mv));
    expect_out({tag, ".rs_wen"}, 8, int'(acc && Rs_Wen_In && !Is_Call && !Is_Rtn));
    expect_out({tag, ".fp_move"}, 9, int'(mv));
    expect_out({tag, ".push_up"}, 10, int'(mv && call_ok));
    expect_out({tag, ".new_fp"}, 11, mv ? (call_ok ? m_fp + int'(Call_Offset) : m_fp - top) : m_fp);
    expect_out({tag, ".cur_fp"}, 12, m_fp);
    expect_out({tag, ".depth"}, 13, m_stk.size());
    expect_out({tag, ".fault"}, 14, m_fault);
  endfunction

  function automatic void model_edge();
    if (m_state == 1) m_state = 0;
    else if (m_state == 0 && Instr_Valid) begin
      if (Is_Call && Is_Rtn) begin
        m_state = 2; m_fault = 1;
      end else if (Is_Call) begin
        if (m_fp + int'(Call_Offset) > 8 || m_stk.size() == 8) begin
          m_state = 2; m_fault = 1;
        end else begin
          m_fp = m_fp + int'(Call_Offset);
          m_stk.push_back(int'(Call_Offset));
          m_state = 1;
        end
      end else if (Is_Rtn) begin
        if (m_stk.size() == 0) begin
          m_state = 2; m_fault = 1;
        end else begin
          m_fp = m_fp - m_stk.pop_back();
          m_state = 1;
        end
      end
    end
  endfunction

  function automatic void model_reset();
    m_state = 0; m_fp = 0; m_fault = 0;
    m_stk.delete();
  endfunction

  task automatic drain();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(e.tag, obs(e.sel), e.val);
    end
  endtask

  // One clock: drive at negedge, compare combinational outputs, then step the model at posedge.
  task automatic cyc(input string tag, input bit v, input bit c, input bit r, input int off,
                     input int rd, input int rs, input int rm, input bit rdw, input bit rsw);
    @(negedge Clock);
    Instr_Valid = v; Is_Call = c; Is_Rtn = r; Call_Offset = 3'(off);
    Rel_Rd = 3'(rd); Rel_Rs = 3'(rs); Rel_Rm = 3'(rm);
    Rd_Wen_In = rdw; Rs_Wen_In = rsw;
    #1;
    model_expect(tag);
    drain();
    @(posedge Clock);
    if (!Reset) model_edge();
  endtask

  task automatic do_reset(input string tag);
    @(negedge Clock);
    #2;
    Reset = 1'b1;
    #1;
    model_reset();
    expect_out({tag, ".async_fault"}, 14, 0);
    expect_out({tag, ".async_ready"}, 0, 1);
    expect_out({tag, ".async_fp"}, 12, 0);
    drain();
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge Clock);
    Reset = 1'b0;

    expect_out("rst_newfp", 11, 0);
    expect_out("rst_rdwen", 7, 0);
    cyc("rst_idle", 0, 0, 0, 0, 0, 0, 0, 1, 1);

    expect_out("plain_rdaddr", 1, 3);
    expect_out("plain_rdwen", 7, 1);
    cyc("plain", 1, 0, 0, 0, 3, 1, 6, 1, 1);

    expect_out("call4_newfp", 11, 4);
    expect_out("call4_actrs", 5, 4);
    expect_out("call4_pushup", 10, 1);
    cyc("call4", 1, 1, 0, 4, 2, 7, 1, 1, 1);
    expect_out("settle_ready", 0, 0);
    cyc("settle1", 1, 0, 0, 0, 1, 1, 1, 1, 1);
    expect_out("win4_rmaddr", 3, 9);
    expect_out("win4_depth", 13, 1);
    cyc("win4", 1, 0, 0, 0, 7, 7, 5, 0, 1);

    cyc("call4b", 1, 1, 0, 4, 0, 0, 0, 1, 0);
    cyc("settle2", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_out("fp8_cur", 12, 8);
    expect_out("rtn_newfp", 11, 4);
    expect_out("rtn_actrs", 5, 4);
    expect_out("rtn_pushup", 10, 0);
    cyc("rtn", 1, 0, 1, 0, 3, 2, 1, 1, 1);
    cyc("settle3", 1, 0, 0, 0, 0, 0, 0, 1, 1);
    expect_out("after_rtn_depth", 13, 1);
    cyc("call4c", 1, 1, 0, 4, 0, 0, 0, 0, 0);
    cyc("settle4", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    expect_out("ovf_rdwen", 7, 0);
    cyc("call_ovf", 1, 1, 0, 1, 2, 2, 2, 1, 1);
    expect_out("flt_fault", 14, 1);
    expect_out("flt_fp", 12, 8);
    for (int i = 0; i < 3; i++) cyc("in_fault", 1, 0, 0, 0, i, i, i, 1, 1);
    do_reset("rst1");

    cyc("rtn_empty", 1, 0, 1, 0, 0, 0, 0, 1, 0);
    expect_out("rtn_empty_fault", 14, 1);
    cyc("rtn_empty_after", 1, 0, 0, 0, 0, 0, 0, 1, 0);
    do_reset("rst2");

    for (int i = 0; i < 9; i++) begin
      cyc("call0", 1, 1, 0, 0, i % 8, 1, 2, 1, 1);
      cyc("call0_settle", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    end
    expect_out("full_fault", 14, 1);
    expect_out("full_depth", 13, 8);
    cyc("full_after", 1, 0, 0, 0, 0, 0, 0, 1, 1);
    do_reset("rst3");

    cyc("both", 1, 1, 1, 2, 4, 5, 6, 1, 1);
    expect_out("both_fault", 14, 1);
    cyc("both_after", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset("rst4");
    cyc("final", 1, 0, 0, 0, 5, 6, 7, 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
